sqrt_round_pack: RTL and testbench
==================================

Name: sqrt_round_pack

Overview:
- Output stage directly downstream of SquareRootModule in the lampFPU sqrt/inverse-sqrt datapath.
- Captures the operation context (result exponent, invSqrt flag, special-case bypass) when the operation is issued.
- Waits for the iterative root's valid, then normalizes the 2*(1+LAMP_FLOAT_F_DW)-bit fixed-point root, rounds to nearest-even and packs a bfloat16-style word (1/8/7).
- Two-stage registered post-processing; no denormals.

Parameters:
- None. Widths come from lampFPU_pkg: LAMP_FLOAT_DW=16, LAMP_FLOAT_E_DW=8, LAMP_FLOAT_F_DW=7, LAMP_FLOAT_E_BIAS=127.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
doSqrt_i  in  1  issue pulse; same signal that starts SquareRootModule
res_exp_i  in  8  biased result exponent from the upstream unpack stage, sampled on issue
invSqrt_i  in  1  operation is 1/sqrt, sampled on issue
special_case_i  in  1  operand is special (NaN, inf, zero, negative), sampled on issue
special_res_i  in  16  packed result to return for a special case, sampled on issue
sqrt_valid_i  in  1  valid_o of SquareRootModule
sqrt_res_i  in  16  res_o of SquareRootModule, unsigned Q2.14, value in [0.5,2)
busy_o  out  1  operation in flight; issues are ignored while high
valid_o  out  1  one-cycle pulse, result_o valid
result_o  out  16  packed float result {sign, exp[7:0], frac[6:0]}

Behaviour:
- Reset: state=IDLE; busy_o=0, valid_o=0, result_o=16'h0000; context registers cleared. A reset in any state aborts the operation; no valid_o is produced for it.
- FSM states: IDLE, WAIT, NORM, ROUND, SPEC.
- IDLE:
  - doSqrt_i=1 latches res_exp_i, invSqrt_i, special_case_i and special_res_i.
  - Next state is SPEC if special_case_i=1, otherwise WAIT.
  - sqrt_valid_i is ignored in IDLE.
- SPEC: result_o<=special_res_i, valid_o pulses, then IDLE. valid_o rises at the edge after the issue edge. A later sqrt_valid_i from the still-running root is ignored.
- WAIT:
  - sqrt_valid_i=1 latches sqrt_res_i, then NORM.
  - doSqrt_i is ignored in WAIT, NORM and ROUND; busy_o=1 in those states and in SPEC.
- NORM (registers normalized fields):
  - If res[14]=1: frac=res[13:7], guard=res[6], sticky=|res[5:0], exp=res_exp.
  - Else if res[13]=1: frac=res[12:6], guard=res[5], sticky=|res[4:0], exp=res_exp-1.
  - Else: force the zero result.
  - Exponent arithmetic uses 10-bit signed.
- ROUND (result registered, valid_o pulses, then IDLE):
  - RNE: increment when guard & (sticky | frac[0]).
  - On frac carry-out: frac=0, exp+1.
  - exp>=255: result 16'h7F80 (+inf).
  - exp<=0: result 16'h0000 (flush to zero).
  - Sign is always 0.
- Latency: sqrt_valid_i sampled at edge k gives valid_o=1 during the cycle after edge k+3. That is: k capture, k+1 NORM regs, k+2 ROUND regs, k+3 output regs. Exactly one cycle.
- result_o holds its value after the pulse until the next completion or reset.
- invSqrt_i only selects that the [0.5,1) input range is legal. The normalization path is shared.
- sqrt_res_i value >= 2.0 (res[15]=1) is illegal. The bench asserts on it; the RTL treats it as the res[14] path on res[14:0].

Decomposition:
- lampFPU_pkg gains:
  - constants LAMP_FLOAT_INF=16'h7F80 and LAMP_FLOAT_ZERO=16'h0000;
  - enum sqrtPackState_t {IDLE, WAIT, NORM, ROUND, SPEC};
  - function FUNC_rne(frac, guard, sticky) returning {carry, frac}.
- No sub-module is needed; the rounding logic is the package function.

Test Plan:
- sqrt(2.0): issue res_exp_i=127; sqrt_res_i=16'h5A82 -> valid_o pulse 3 cycles later, result_o=16'h3FB5.
- invSqrt(4.0): invSqrt_i=1, res_exp_i=127, sqrt_res_i=16'h2000 -> result_o=16'h3F00 (0.5).
- RNE checks with res_exp_i=127:
  - 16'h4040 (tie, lsb 0) -> 16'h3F80.
  - 16'h40C0 (tie, lsb 1) -> 16'h3F82.
  - 16'h7FFF (carry) -> 16'h4000.
- Range limits:
  - res_exp_i=254 with 16'h7FFF -> 16'h7F80.
  - res_exp_i=0 with 16'h2000 -> 16'h0000.
- Special and abort:
  - special_case_i=1, special_res_i=16'h7FC0 -> valid_o at the next edge with result_o=16'h7FC0. A later sqrt_valid_i produces no pulse.
  - A second doSqrt_i during WAIT is ignored (busy_o=1).
  - rst asserted in NORM -> no valid_o; result_o=16'h0000.

Source files
------------

// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions used by the sqrt/inverse-sqrt output stage:
// float field widths, packed special constants, the pack FSM state type
// and the round-to-nearest-even helper.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW     = 16;
  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_E_BIAS = 127;

  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_INF  = 16'h7F80;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    SPEC  = 3'd4
  } sqrtPackState_t;

  // Round to nearest, ties to even. Returns {carry, frac}; a set carry means
  // the fraction wrapped to zero and the exponent must be bumped by one.
  function automatic logic [LAMP_FLOAT_F_DW:0] FUNC_rne(
    input logic [LAMP_FLOAT_F_DW-1:0] frac,
    input logic                       guard,
    input logic                       sticky
  );
    logic w_inc;
    w_inc = guard & (sticky | frac[0]);
    return {1'b0, frac} + {{LAMP_FLOAT_F_DW{1'b0}}, w_inc};
  endfunction

endpackage

// File: rtl/sqrt_round_pack_if.sv
// Issue/context and root-result bundle between the sqrt control path,
// SquareRootModule and the round/pack output stage.
interface sqrt_round_pack_if;
  import lampFPU_pkg::*;

  logic                         doSqrt_i;
  logic [LAMP_FLOAT_E_DW-1:0]   res_exp_i;
  logic                         invSqrt_i;
  logic                         special_case_i;
  logic [LAMP_FLOAT_DW-1:0]     special_res_i;
  logic                         sqrt_valid_i;
  logic [2*(1+LAMP_FLOAT_F_DW)-1:0] sqrt_res_i;
  logic                         busy_o;
  logic                         valid_o;
  logic [LAMP_FLOAT_DW-1:0]     result_o;

  // Upstream side: issues operations and supplies the root.
  modport master (
    output doSqrt_i, res_exp_i, invSqrt_i, special_case_i, special_res_i,
    output sqrt_valid_i, sqrt_res_i,
    input  busy_o, valid_o, result_o
  );

  // Output stage side.
  modport slave (
    input  doSqrt_i, res_exp_i, invSqrt_i, special_case_i, special_res_i,
    input  sqrt_valid_i, sqrt_res_i,
    output busy_o, valid_o, result_o
  );

endinterface

// File: rtl/sqrt_round_pack.sv
// Output stage of the lampFPU sqrt / inverse-sqrt datapath. Captures the
// operation context on issue, waits for the iterative root, then normalizes,
// rounds (RNE) and packs a 1/8/7 float. Special operands bypass the root.
module sqrt_round_pack
  import lampFPU_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sqrt_round_pack_if.slave bus
);

  typedef struct packed {
    logic [LAMP_FLOAT_E_DW-1:0] res_exp;
    logic                       inv_sqrt;
    logic                       special;
    logic [LAMP_FLOAT_DW-1:0]   special_res;
  } ctx_t;

  sqrtPackState_t r_state, w_next;
  ctx_t           r_ctx;

  logic [15:0]                r_sqrt_res;
  logic [LAMP_FLOAT_F_DW-1:0] r_n_frac;
  logic                       r_n_guard;
  logic                       r_n_sticky;
  logic signed [9:0]          r_n_exp;
  logic                       r_n_zero;
  logic [LAMP_FLOAT_DW-1:0]   r_rnd_res;
  logic                       r_fin;
  logic                       r_valid;
  logic [LAMP_FLOAT_DW-1:0]   r_result;

  logic                       w_issue;
  logic                       w_capture;
  logic                       w_busy;
  logic [LAMP_FLOAT_F_DW-1:0] w_n_frac;
  logic                       w_n_guard;
  logic                       w_n_sticky;
  logic signed [9:0]          w_n_exp;
  logic                       w_n_zero;
  logic [LAMP_FLOAT_F_DW:0]   w_rne;
  logic signed [9:0]          w_r_exp;
  logic [LAMP_FLOAT_DW-1:0]   w_rnd_res;
  logic                       w_unused;

  // The root range check that invSqrt selects lives upstream; the shared
  // normalization path never needs the latched flag.
  assign w_unused = &{1'b0, r_ctx.inv_sqrt};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    w_next    = r_state;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_busy    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_issue = bus.doSqrt_i;
        if (bus.doSqrt_i) w_next = bus.special_case_i ? SPEC : WAIT;
      end
      WAIT: begin
        w_capture = bus.sqrt_valid_i;
        if (bus.sqrt_valid_i) w_next = NORM;
      end
      NORM:    w_next = ROUND;
      ROUND:   w_next = IDLE;
      SPEC:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operation context, held from issue until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctx <= '0;
    end else if (w_issue) begin
      r_ctx.res_exp     <= bus.res_exp_i;
      r_ctx.inv_sqrt    <= bus.invSqrt_i;
      r_ctx.special     <= bus.special_case_i;
      r_ctx.special_res <= bus.special_res_i;
    end
  end

  // Normalization of the Q2.14 root. An out-of-range root (bit 15 set) is
  // folded onto the [1,2) path; a root below 0.5 collapses to zero.
  always_comb begin
    w_n_frac   = '0;
    w_n_guard  = 1'b0;
    w_n_sticky = 1'b0;
    w_n_exp    = '0;
    w_n_zero   = 1'b0;
    if (r_sqrt_res[15] | r_sqrt_res[14]) begin
      w_n_frac   = r_sqrt_res[13:7];
      w_n_guard  = r_sqrt_res[6];
      w_n_sticky = |r_sqrt_res[5:0];
      w_n_exp    = signed'({2'b00, r_ctx.res_exp});
    end else if (r_sqrt_res[13]) begin
      w_n_frac   = r_sqrt_res[12:6];
      w_n_guard  = r_sqrt_res[5];
      w_n_sticky = |r_sqrt_res[4:0];
      w_n_exp    = signed'({2'b00, r_ctx.res_exp}) - 10'sd1;
    end else begin
      w_n_zero   = 1'b1;
    end
  end

  // Rounding, exponent adjust and range clamp to +inf / flush to zero.
  always_comb begin
    w_rne   = FUNC_rne(r_n_frac, r_n_guard, r_n_sticky);
    w_r_exp = r_n_exp + signed'({9'd0, w_rne[LAMP_FLOAT_F_DW]});
    if (r_n_zero)               w_rnd_res = LAMP_FLOAT_ZERO;
    else if (w_r_exp >= 10'sd255) w_rnd_res = LAMP_FLOAT_INF;
    else if (w_r_exp <= 10'sd0)   w_rnd_res = LAMP_FLOAT_ZERO;
    else w_rnd_res = {1'b0, w_r_exp[LAMP_FLOAT_E_DW-1:0], w_rne[LAMP_FLOAT_F_DW-1:0]};
  end

  // Pipeline registers: root capture, normalized fields, rounded result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sqrt_res <= '0;
      r_n_frac   <= '0;
      r_n_guard  <= 1'b0;
      r_n_sticky <= 1'b0;
      r_n_exp    <= '0;
      r_n_zero   <= 1'b0;
      r_rnd_res  <= '0;
      r_fin      <= 1'b0;
    end else begin
      if (w_capture) r_sqrt_res <= bus.sqrt_res_i;
      if (r_state == NORM) begin
        r_n_frac   <= w_n_frac;
        r_n_guard  <= w_n_guard;
        r_n_sticky <= w_n_sticky;
        r_n_exp    <= w_n_exp;
        r_n_zero   <= w_n_zero;
      end
      if (r_state == ROUND) r_rnd_res <= w_rnd_res;
      r_fin <= (r_state == ROUND);
    end
  end

  // Output registers: one-cycle valid pulse, result held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= LAMP_FLOAT_ZERO;
    end else begin
      r_valid <= (r_state == SPEC) | r_fin;
      if ((r_state == SPEC) | r_fin)
        r_result <= r_ctx.special ? r_ctx.special_res : r_rnd_res;
    end
  end

  assign bus.busy_o   = w_busy;
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_sqrt_round_pack.sv
// Directed bench for sqrt_round_pack: expected results are queued when an
// operation is issued and compared whenever valid_o pulses.
module tb_sqrt_round_pack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sqrt_round_pack_if bus();

  sqrt_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          n_valid = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  e;
    logic        inv;
    logic [15:0] res;
    logic [15:0] expv;
  } op_t;

  op_t ops[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every valid pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (bus.sqrt_valid_i === 1'b1 && bus.sqrt_res_i[15] === 1'b1) begin
      bad++;
      $error("FAIL illegal_root: observed=%h expected below 8000", bus.sqrt_res_i);
    end
    if (bus.valid_o === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_valid: observed result=%h expected no pulse", bus.result_o);
      end else begin
        check("result", bus.result_o, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [7:0] e, input logic inv, input logic sp,
                       input logic [15:0] sres);
    @(negedge clk);
    bus.doSqrt_i       = 1'b1;
    bus.res_exp_i      = e;
    bus.invSqrt_i      = inv;
    bus.special_case_i = sp;
    bus.special_res_i  = sres;
    @(negedge clk);
    // Scramble the context inputs so only the issue-time values can matter.
    bus.doSqrt_i       = 1'b0;
    bus.res_exp_i      = ~e;
    bus.invSqrt_i      = ~inv;
    bus.special_case_i = ~sp;
    bus.special_res_i  = ~sres;
  endtask

  task automatic root(input logic [15:0] res);
    @(negedge clk);
    bus.sqrt_valid_i = 1'b1;
    bus.sqrt_res_i   = res;
    @(negedge clk);
    bus.sqrt_valid_i = 1'b0;
    bus.sqrt_res_i   = 16'h1234;
  endtask

  // Called on the negedge right after the triggering edge.
  task automatic wait_valid(input string tag, input int lat_exp);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.valid_o === 1'b1) seen = 1;
    end
    if (!seen) lat = 99;
    check({tag, "_latency"}, 16'(lat), 16'(lat_exp));
    @(posedge clk);
    #1;
    check({tag, "_one_cycle"}, {15'd0, bus.valid_o}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time limit expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    bus.doSqrt_i = 1'b0; bus.res_exp_i = '0; bus.invSqrt_i = 1'b0;
    bus.special_case_i = 1'b0; bus.special_res_i = '0;
    bus.sqrt_valid_i = 1'b0; bus.sqrt_res_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",   {15'd0, bus.busy_o},  16'h0000);
    check("reset_valid",  {15'd0, bus.valid_o}, 16'h0000);
    check("reset_result", bus.result_o,         16'h0000);
    rst = 1'b0;

    // Normal path: sqrt, invSqrt, RNE ties/carry, range limits, zero force.
    ops.push_back('{8'd127, 1'b0, 16'h5A82, 16'h3FB5});
    ops.push_back('{8'd127, 1'b1, 16'h2000, 16'h3F00});
    ops.push_back('{8'd127, 1'b0, 16'h4040, 16'h3F80});
    ops.push_back('{8'd127, 1'b0, 16'h40C0, 16'h3F82});
    ops.push_back('{8'd127, 1'b0, 16'h7FFF, 16'h4000});
    ops.push_back('{8'd254, 1'b0, 16'h7FFF, 16'h7F80});
    ops.push_back('{8'd0,   1'b1, 16'h2000, 16'h0000});
    ops.push_back('{8'd200, 1'b0, 16'h4000, 16'h6400});
    ops.push_back('{8'd127, 1'b0, 16'h4041, 16'h3F81});
    ops.push_back('{8'd127, 1'b1, 16'h3FFF, 16'h3F80});
    ops.push_back('{8'd1,   1'b1, 16'h2000, 16'h0000});
    ops.push_back('{8'd127, 1'b0, 16'h5A82, 16'h3FB5});
    ops.push_back('{8'd127, 1'b0, 16'h1FFF, 16'h0000});
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].expv);
      issue(ops[i].e, ops[i].inv, 1'b0, 16'h0000);
      check("busy_wait", {15'd0, bus.busy_o}, 16'h0001);
      root(ops[i].res);
      wait_valid("op", 3);
    end

    // Special bypass: valid one edge after issue, later root ignored.
    exp_q.push_back(16'h7FC0);
    issue(8'd127, 1'b0, 1'b1, 16'h7FC0);
    wait_valid("spec", 1);
    nv = n_valid;
    root(16'h5A82);
    repeat (6) @(negedge clk);
    check("spec_late_root", 16'(n_valid - nv), 16'h0000);
    check("spec_idle_busy", {15'd0, bus.busy_o}, 16'h0000);

    // Second issue while waiting for the root is ignored.
    exp_q.push_back(16'h3FB5);
    nv = n_valid;
    issue(8'd127, 1'b0, 1'b0, 16'h0000);
    issue(8'd10, 1'b1, 1'b1, 16'h1234);
    check("busy_second_issue", {15'd0, bus.busy_o}, 16'h0001);
    root(16'h5A82);
    wait_valid("double", 3);
    check("double_pulses", 16'(n_valid - nv), 16'h0001);

    // Reset while in NORM aborts with no pulse and clears the result.
    issue(8'd127, 1'b0, 1'b0, 16'h0000);
    root(16'h5A82);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv = n_valid;
    repeat (6) @(negedge clk);
    check("abort_pulses", 16'(n_valid - nv), 16'h0000);
    check("abort_result", bus.result_o, 16'h0000);
    check("abort_busy", {15'd0, bus.busy_o}, 16'h0000);

    check("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
